// File: rtl/embcpu4k_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared constants for the OCI direct-branch trace code packer.
package embcpu4k_nios2_qsys_0_oci_dct_packer_pkg;
    localparam int SLOTS   = 15;
    localparam int FRAME_W = 2 * SLOTS;
    localparam int CNT_W   = 4;

    localparam logic [1:0] DCT_NT = 2'b01;
    localparam logic [1:0] DCT_TK = 2'b10;

    function automatic logic is_legal(input logic [1:0] code);
        return (code == DCT_NT) || (code == DCT_TK);
    endfunction
endpackage

// File: rtl/embcpu4k_nios2_qsys_0_oci_dct_slot.sv
// Single-entry valid/ready output register holding one packed frame.
module embcpu4k_nios2_qsys_0_oci_dct_slot
    import embcpu4k_nios2_qsys_0_oci_dct_packer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_buf,
    input  logic [CNT_W-1:0]   load_cnt,
    input  logic               out_ready,
    output logic               slot_free,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_buffer,
    output logic [CNT_W-1:0]   frame_count
);
    // Free when empty or draining this cycle, so a load can overlap a transfer.
    assign slot_free = ~frame_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid  <= 1'b0;
            frame_buffer <= '0;
            frame_count  <= '0;
        end else if (load) begin
            frame_valid  <= 1'b1;
            frame_buffer <= load_buf;
            frame_count  <= load_cnt;
        end else if (frame_valid && out_ready) begin
            frame_valid  <= 1'b0;
            frame_buffer <= '0;
            frame_count  <= '0;
        end
    end
endmodule

// File: rtl/embcpu4k_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit direct-branch trace codes into 15-code frames for the OCI trace consumer.
module embcpu4k_nios2_qsys_0_oci_dct_packer
    import embcpu4k_nios2_qsys_0_oci_dct_packer_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trc_on,
    input  logic               dct_valid,
    input  logic [1:0]         dct_code,
    input  logic               flush,
    input  logic               out_ready,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_buffer,
    output logic [CNT_W-1:0]   frame_count,
    output logic               overflow,
    output logic [DROP_W-1:0]  dropped,
    output logic               illegal_code
);
    logic [FRAME_W-1:0] acc, acc_d, ins_buf, load_buf;
    logic [CNT_W-1:0]   acc_cnt, cnt_d, ins_cnt, load_cnt;
    logic               trc_on_d, pend_flush, pend_d;
    logic               ev, fall, slot_free, load, drop, accept, trig;

    assign ev   = trc_on & dct_valid;
    assign fall = trc_on_d & ~trc_on;

    always_comb begin
        acc_d    = acc;
        cnt_d    = acc_cnt;
        pend_d   = pend_flush;
        ins_buf  = acc;
        ins_cnt  = acc_cnt;
        load_buf = acc;
        load_cnt = acc_cnt;
        load     = 1'b0;
        drop     = 1'b0;
        accept   = 1'b0;
        trig     = 1'b0;
        if (acc_cnt == CNT_W'(SLOTS)) begin
            // Full accumulator: emit it as-is; a same-cycle event starts the next frame.
            if (slot_free) begin
                load   = 1'b1;
                accept = ev;
                acc_d  = ev ? {{(FRAME_W-2){1'b0}}, dct_code} : '0;
                cnt_d  = ev ? CNT_W'(1) : '0;
                pend_d = 1'b0;
            end else begin
                drop = ev;
            end
        end else begin
            accept   = ev;
            ins_buf  = ev ? {acc[FRAME_W-3:0], dct_code} : acc;
            ins_cnt  = acc_cnt + CNT_W'(ev);
            load_buf = ins_buf;
            load_cnt = ins_cnt;
            trig     = (ins_cnt == CNT_W'(SLOTS)) ||
                       ((flush | pend_flush | fall) && (ins_cnt != '0));
            if (trig && slot_free) begin
                load   = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else begin
                acc_d  = ins_buf;
                cnt_d  = ins_cnt;
                pend_d = pend_flush | ((flush | fall) && (ins_cnt != '0));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            acc_cnt      <= '0;
            pend_flush   <= 1'b0;
            trc_on_d     <= 1'b0;
            overflow     <= 1'b0;
            dropped      <= '0;
            illegal_code <= 1'b0;
        end else begin
            acc          <= acc_d;
            acc_cnt      <= cnt_d;
            pend_flush   <= pend_d;
            trc_on_d     <= trc_on;
            illegal_code <= accept & ~is_legal(dct_code);
            if (drop) begin
                overflow <= 1'b1;
                if (dropped != '1) dropped <= dropped + 1'b1;
            end
        end
    end

    embcpu4k_nios2_qsys_0_oci_dct_slot u_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .load_buf     (load_buf),
        .load_cnt     (load_cnt),
        .out_ready    (out_ready),
        .slot_free    (slot_free),
        .frame_valid  (frame_valid),
        .frame_buffer (frame_buffer),
        .frame_count  (frame_count)
    );
endmodule

// File: tb/tb_embcpu4k_nios2_qsys_0_oci_dct_packer.sv
// Randomized and directed bench for the DCT packer against a queue-based reference model.
module tb_embcpu4k_nios2_qsys_0_oci_dct_packer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trc_on = 1'b0, dct_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [1:0]  dct_code = 2'b00;
    logic        frame_valid, overflow, illegal_code;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic [7:0]  dropped;

    int checks = 0;
    int failures = 0;

    // Reference model state: pending codes oldest-first, plus the presented frame.
    bit [1:0]  mq[$];
    bit        m_pend, m_trc_d, m_sv, m_ovf, m_ill;
    bit [29:0] m_sbuf;
    int        m_scnt, m_drop;

    always #5 clk = ~clk;

    embcpu4k_nios2_qsys_0_oci_dct_packer #(.DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .dct_valid(dct_valid),
        .dct_code(dct_code), .flush(flush), .out_ready(out_ready),
        .frame_valid(frame_valid), .frame_buffer(frame_buffer), .frame_count(frame_count),
        .overflow(overflow), .dropped(dropped), .illegal_code(illegal_code)
    );

    function automatic bit [29:0] pack_q();
        bit [29:0] v = '0;
        foreach (mq[i]) v = (v << 2) | 30'(mq[i]);
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_trc_d = 0; m_sv = 0; m_ovf = 0; m_ill = 0;
        m_sbuf = '0; m_scnt = 0; m_drop = 0;
    endtask

    task automatic emit_q();
        m_sv = 1; m_sbuf = pack_q(); m_scnt = mq.size();
        mq.delete(); m_pend = 0;
    endtask

    task automatic model_step();
        bit free, ev, fall, ill_n, hit;
        free  = !m_sv || out_ready;
        ev    = trc_on && dct_valid;
        fall  = m_trc_d && !trc_on;
        ill_n = ev && !(dct_code == 2'b01 || dct_code == 2'b10);
        if (mq.size() == 15) begin
            if (free) begin
                emit_q();
                if (ev) mq.push_back(dct_code);
            end else if (ev) begin
                ill_n = 0; m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end else begin
            if (ev) mq.push_back(dct_code);
            hit = (mq.size() == 15) || ((flush || m_pend || fall) && mq.size() > 0);
            if (hit && free) emit_q();
            else begin
                if (m_sv && out_ready) begin m_sv = 0; m_sbuf = '0; m_scnt = 0; end
                if ((flush || fall) && mq.size() > 0) m_pend = 1;
            end
        end
        m_ill = ill_n;
        m_trc_d = trc_on;
    endtask

    task automatic drive(input bit t, input bit v, input bit [1:0] c, input bit f, input bit r);
        @(negedge clk);
        trc_on = t; dct_valid = v; dct_code = c; flush = f; out_ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; trc_on = 0; dct_valid = 0; flush = 0; out_ready = 0; dct_code = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({frame_valid, frame_buffer, frame_count, overflow, dropped, illegal_code} !== '0) begin
            failures++;
            $display("FAIL reset_state: got fv=%b buf=%h cnt=%0d ovf=%b drop=%0d ill=%b want all 0",
                     frame_valid, frame_buffer, frame_count, overflow, dropped, illegal_code);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 14; i++) drive(1, 1, 2'b10, 0, 1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL full_early: fv=%b want 0", frame_valid);
        end
        drive(1, 1, 2'b10, 0, 1);
        checks++;
        if (frame_valid !== 1'b1 || frame_buffer !== 30'h2AAAAAAA || frame_count !== 4'd15 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_frame: fv=%b buf=%h cnt=%0d ovf=%b want 1 2aaaaaaa 15 0",
                     frame_valid, frame_buffer, frame_count, overflow);
        end
        drive(1, 0, 2'b00, 0, 1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL full_drain: fv=%b want 0", frame_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 2'b01, 0, 1);
        drive(1, 1, 2'b10, 0, 1);
        drive(1, 1, 2'b01, 0, 1);
        drive(1, 0, 2'b00, 1, 1);
        checks++;
        if (frame_valid !== 1'b1 || frame_buffer !== 30'h19 || frame_count !== 4'd3) begin
            failures++;
            $display("FAIL flush_partial: fv=%b buf=%h cnt=%0d want 1 19 3", frame_valid, frame_buffer, frame_count);
        end
        drive(1, 0, 2'b00, 1, 1);
        drive(1, 0, 2'b00, 1, 1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL flush_empty: fv=%b want 0 (accumulator should be empty)", frame_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 15; i++) drive(1, 1, 2'b10, 0, 0);
        for (int i = 0; i < 15; i++) drive(1, 1, 2'b01, 0, 0);
        checks++;
        if (overflow !== 1'b0 || frame_buffer !== 30'h2AAAAAAA) begin
            failures++; $display("FAIL ovf_before: ovf=%b buf=%h want 0 2aaaaaaa", overflow, frame_buffer);
        end
        drive(1, 1, 2'b10, 0, 0);
        drive(1, 1, 2'b10, 0, 0);
        checks++;
        if (overflow !== 1'b1 || dropped !== 8'd2 || frame_valid !== 1'b1 || frame_count !== 4'd15) begin
            failures++;
            $display("FAIL ovf_drop: ovf=%b drop=%0d fv=%b cnt=%0d want 1 2 1 15", overflow, dropped, frame_valid, frame_count);
        end
        drive(1, 0, 2'b00, 0, 1);
        checks++;
        if (frame_valid !== 1'b1 || frame_buffer !== 30'h15555555 || frame_count !== 4'd15) begin
            failures++;
            $display("FAIL ovf_frame_b: fv=%b buf=%h cnt=%0d want 1 15555555 15", frame_valid, frame_buffer, frame_count);
        end
        drive(1, 0, 2'b00, 0, 1);
        checks++;
        if (frame_valid !== 1'b0 || overflow !== 1'b1 || dropped !== 8'd2) begin
            failures++;
            $display("FAIL ovf_sticky: fv=%b ovf=%b drop=%0d want 0 1 2", frame_valid, overflow, dropped);
        end
    endtask

    task automatic test_event_flush();
        do_reset();
        drive(1, 1, 2'b10, 1, 1);
        checks++;
        if (frame_valid !== 1'b1 || frame_buffer !== 30'h2 || frame_count !== 4'd1) begin
            failures++;
            $display("FAIL event_flush: fv=%b buf=%h cnt=%0d want 1 2 1", frame_valid, frame_buffer, frame_count);
        end
    endtask

    task automatic test_trc_fall();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 1, 2'b01, 0, 1);
        drive(0, 0, 2'b00, 0, 1);
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd5 || frame_buffer !== 30'h155) begin
            failures++;
            $display("FAIL trc_fall: fv=%b buf=%h cnt=%0d want 1 155 5", frame_valid, frame_buffer, frame_count);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 2'b10, 0, 1);
        drive(0, 0, 2'b00, 1, 1);
        checks++;
        if (frame_valid !== 1'b0 || illegal_code !== 1'b0) begin
            failures++; $display("FAIL trc_off_ignored: fv=%b ill=%b want 0 0", frame_valid, illegal_code);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1, 1, 2'b11, 0, 1);
        checks++;
        if (illegal_code !== 1'b1) begin
            failures++; $display("FAIL illegal_pulse: ill=%b want 1", illegal_code);
        end
        drive(1, 0, 2'b00, 1, 1);
        checks++;
        if (illegal_code !== 1'b0 || frame_buffer !== 30'h3 || frame_count !== 4'd1) begin
            failures++;
            $display("FAIL illegal_packed: ill=%b buf=%h cnt=%0d want 0 3 1", illegal_code, frame_buffer, frame_count);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int phase;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            phase = (n / 200) % 3;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 19) == 0,
                  phase == 0 ? ($urandom_range(0, 1) == 1) :
                  phase == 1 ? ($urandom_range(0, 15) == 0) : 1'b1);
            checks++;
            if (frame_valid !== m_sv || frame_buffer !== m_sbuf || frame_count !== 4'(m_scnt) ||
                overflow !== m_ovf || dropped !== 8'(m_drop) || illegal_code !== m_ill) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: got fv=%b buf=%h cnt=%0d ovf=%b drop=%0d ill=%b want %b %h %0d %b %0d %b",
                             n, frame_valid, frame_buffer, frame_count, overflow, dropped, illegal_code,
                             m_sv, m_sbuf, m_scnt, m_ovf, m_drop, m_ill);
                bad++;
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 18; i++) drive(1, 1, 2'b10, 0, 0);
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++; $display("FAIL async_setup: fv=%b want 1", frame_valid);
        end
        @(posedge clk);
        #2 reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({frame_valid, frame_buffer, frame_count, overflow, dropped, illegal_code} !== '0) begin
            failures++;
            $display("FAIL async_reset: fv=%b buf=%h cnt=%0d ovf=%b drop=%0d ill=%b want all 0",
                     frame_valid, frame_buffer, frame_count, overflow, dropped, illegal_code);
        end
        @(negedge clk);
        reset_n = 1; trc_on = 0; dct_valid = 0; flush = 0;
        for (int i = 0; i < 4; i++) drive(0, 0, 2'b00, 1, 1);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL async_no_frame: fv=%b want 0", frame_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_overflow();
        test_event_flush();
        test_trc_fall();
        test_illegal();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
